// File: rtl/bus_decoder.sv
// bus_decoder: address decoder / single-outstanding bus bridge from one master to NUM_DEVICES+1 channels.
// Latency: dev_enables one cycle after request acceptance; mem_ready the cycle after dev_ready[sel].
// Backpressure: master holds in WAIT until the selected channel is ready (or the optional timeout fires).
// Optional feature macro: BUS_DECODER_TIMEOUT_EN enables the wait counter and bus-error completion.
module bus_decoder #(
  parameter int          NUM_DEVICES = 7,
  parameter logic [31:0] BASE_ADDR   = 32'hffff0000,
  parameter int          REGION_BITS = 4,
  parameter int          TIMEOUT     = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            mem_valid,
  input  logic [31:0]                     mem_addr,
  output logic                            mem_ready,
  output logic [31:0]                     mem_rdata,
  output logic                            mem_error,
  output logic [NUM_DEVICES:0]            dev_enables,
  input  logic [NUM_DEVICES:0]            dev_ready,
  input  logic [32*(NUM_DEVICES+1)-1:0]   dev_rdata
);

  localparam int NCH = NUM_DEVICES + 1;
  localparam int CW  = $clog2(NCH);
  // Total mapped window in bytes; always below 2^32 for legal parameters.
  localparam logic [32:0] SPAN = 33'(NUM_DEVICES) << REGION_BITS;

  // Catch illegal parameter combinations at elaboration.
  if (NUM_DEVICES < 1 || NUM_DEVICES > 15 || REGION_BITS < 2 || REGION_BITS > 16 ||
      TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
    $error("bus_decoder: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       sel;
  logic [32:0]         offset;
  logic [CW-1:0]       dec_ch;
  logic [NUM_DEVICES:0] dec_onehot;
  logic                sel_rdy;
  logic [31:0]         sel_rdata;

  // Offset computed one bit wider: an address below BASE_ADDR borrows into
  // bit 32, which lands it above SPAN, so one compare covers both bounds.
  assign offset = {1'b0, mem_addr} - {1'b0, BASE_ADDR};

  // Address decode to a channel number plus its one-hot enable pattern.
  always_comb begin
    dec_ch     = CW'(NUM_DEVICES);
    dec_onehot = '0;
    if (offset < SPAN) begin
      dec_ch = CW'(offset >> REGION_BITS);
    end
    for (int k = 0; k < NCH; k++) begin
      if (dec_ch == CW'(k)) dec_onehot[k] = 1'b1;
    end
  end

  // Mux ready and read data of the latched channel; other channels are ignored.
  always_comb begin
    sel_rdy   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == CW'(k)) begin
        sel_rdy   = dev_ready[k];
        sel_rdata = dev_rdata[32*k +: 32];
      end
    end
  end

`ifdef BUS_DECODER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt;
  logic        err_q;
  assign mem_error = err_q;

  // Transaction FSM with wait counter; ready wins over a same-cycle timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= '0;
      cnt         <= '0;
      dev_enables <= '0;
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          err_q     <= 1'b0;
          if (mem_valid) begin
            sel         <= dec_ch;
            dev_enables <= dec_onehot;
            cnt         <= '0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (sel_rdy) begin
            mem_rdata   <= sel_rdata;
            mem_ready   <= 1'b1;
            err_q       <= 1'b0;
            dev_enables <= '0;
            state       <= DONE;
          end else if (cnt == TO_LAST) begin
            mem_rdata   <= '0;
            mem_ready   <= 1'b1;
            err_q       <= 1'b1;
            dev_enables <= '0;
            state       <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          mem_ready <= 1'b0;
          err_q     <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign mem_error = 1'b0;

  // Transaction FSM; WAIT persists until the selected channel is ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= '0;
      dev_enables <= '0;
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          if (mem_valid) begin
            sel         <= dec_ch;
            dev_enables <= dec_onehot;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (sel_rdy) begin
            mem_rdata   <= sel_rdata;
            mem_ready   <= 1'b1;
            dev_enables <= '0;
            state       <= DONE;
          end
        end
        DONE: begin
          mem_ready <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: doc/bus_decoder.md
BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 Parameter NUM_DEVICES, default 7; number of mapped device slots; range 1..15.
REQ-002 Parameter BASE_ADDR, default 32'hffff0000; base address of slot 0, aligned to 2^REGION_BITS.
REQ-003 Parameter REGION_BITS, default 4; each slot spans 2^REGION_BITS bytes; range 2..16.
REQ-004 Parameter TIMEOUT, default 255; wait-cycle limit before bus error; range 1..65535.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 mem_valid  input  1  master request strobe.
REQ-008 mem_addr  input  32  master byte address.
REQ-009 mem_ready  output  1  one-cycle completion pulse to master.
REQ-010 mem_rdata  output  32  read data returned with mem_ready.
REQ-011 mem_error  output  1  asserted with mem_ready when the access timed out.
REQ-012 dev_enables  output  NUM_DEVICES+1  one-hot device select; bit NUM_DEVICES is the default (unmapped) channel.
REQ-013 dev_ready  input  NUM_DEVICES+1  per-channel ready.
REQ-014 dev_rdata  input  32*(NUM_DEVICES+1)  per-channel read data; channel k in bits [32k+31:32k].

Function
REQ-015 Decode: if BASE_ADDR <= mem_addr < BASE_ADDR + NUM_DEVICES*2^REGION_BITS, channel = (mem_addr - BASE_ADDR) >> REGION_BITS; otherwise channel = NUM_DEVICES.
REQ-016 FSM states IDLE, WAIT, DONE; reset state IDLE.
REQ-017 IDLE: mem_valid=1 latches decoded channel into sel and clears the wait counter, then -> WAIT; mem_valid=0 stays IDLE.
REQ-018 WAIT: dev_enables is one-hot at bit sel; all other states drive dev_enables to 0.
REQ-019 dev_enables asserts exactly one cycle after the IDLE cycle sampling mem_valid=1.
REQ-020 mem_addr changes during WAIT are ignored; sel stays latched.
REQ-021 WAIT with dev_ready[sel]=1: register mem_rdata = dev_rdata[sel], pulse mem_ready=1 for the next cycle, mem_error=0, -> DONE.
REQ-022 dev_ready bits other than sel are ignored.
REQ-023 DONE: mem_ready=1 for exactly this cycle; unconditionally -> IDLE; master deasserts mem_valid in this cycle.
REQ-024 mem_rdata holds its last value outside DONE; mem_ready and mem_error are 0 outside DONE.
REQ-025 Minimum transaction: valid sampled cycle N, enable cycles N+1.., ready earliest cycle N+2.

Reset
REQ-026 Reset asserted at any time, including mid-WAIT: state=IDLE, sel=0, counter=0, dev_enables=0, mem_ready=0, mem_error=0, mem_rdata=0, within the same cycle (asynchronous).
REQ-027 First request is accepted on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro BUS_DECODER_TIMEOUT_EN defined: wait counter increments each WAIT cycle without dev_ready[sel]; on reaching TIMEOUT -> DONE with mem_ready=1, mem_error=1, mem_rdata=32'h00000000.
REQ-029 dev_ready[sel]=1 in the same cycle the counter reaches TIMEOUT: normal completion wins, mem_error=0.
REQ-030 Macro undefined: no counter logic, mem_error tied 0, WAIT persists until dev_ready[sel].

Verification
REQ-031 Default params, mem_addr=32'hffff0034, mem_valid=1, dev_ready[3]=1 with dev_rdata[3]=32'h12345678 two cycles later -> dev_enables=8'h08, mem_ready one cycle, mem_rdata=32'h12345678, mem_error=0.
REQ-032 mem_addr=32'h00001000 -> dev_enables=8'h80; dev_ready[7]=1 -> completion with dev_rdata[7].
REQ-033 mem_addr=32'hffff0070 (just beyond slot 6) -> default channel 8'h80; mem_addr=32'hffff0060 -> 8'h40.
REQ-034 TIMEOUT_EN, TIMEOUT=4, no dev_ready -> mem_ready=1, mem_error=1, mem_rdata=0 after 4 WAIT cycles; dev_ready[sel] at cycle 4 -> mem_error=0.
REQ-035 Reset asserted mid-WAIT -> dev_enables=0, mem_ready=0 immediately; next request after deassert completes normally.
REQ-036 mem_addr changed from slot 2 to slot 5 during WAIT -> dev_enables stays 8'h04; dev_ready[5] alone does not complete.
